// File: rtl/sw_debounce_ctrl.sv
// Switch bank synchroniser/debouncer with stable-value and sticky change-mask MMIO reads plus level IRQ.
// Define SW_DEBOUNCE_BYPASS_EN to drop the debounce FSM (stable follows sync2 directly, for fast simulation).
module sw_debounce_ctrl #(
  parameter int N_SW            = 16,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [N_SW-1:0] SW,
  input  logic            ADDR_SEL,
  input  logic            RD_EN,
  output logic [31:0]     RD,
  output logic            IRQ
);

  logic [N_SW-1:0] sync1_q, sync2_q;
  logic [N_SW-1:0] stable_q, stable_d;
  logic [N_SW-1:0] chg_q, chg_d;
  logic [N_SW-1:0] commit_new;
  logic            clr_rd;

  // Two-flop synchroniser; SW is asynchronous to CLK
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= SW;
      sync2_q <= sync1_q;
    end
  end

`ifdef SW_DEBOUNCE_BYPASS_EN

  always_comb begin
    stable_d   = sync2_q;
    commit_new = stable_q ^ sync2_q;
  end

`else

  typedef enum logic {
    IDLE,
    SETTLE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t          state_q, state_d;
  logic [N_SW-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            commit;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any movement at sync2 during SETTLE restarts the hold window
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q != stable_q) begin
          state_d = SETTLE;
          cand_d  = sync2_q;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (sync2_q != cand_q) begin
          cand_d = sync2_q;
          cnt_d  = '0;
        end else if (cnt_q < CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A bounce back to the old value commits with a zero XOR, so no spurious change bit
  always_comb begin
    stable_d   = stable_q;
    commit_new = '0;
    if (commit) begin
      stable_d   = cand_q;
      commit_new = stable_q ^ cand_q;
    end
  end

`endif

  assign clr_rd = RD_EN && ADDR_SEL;

  // A clearing read on the same edge as a commit keeps the newly committed bits
  always_comb begin
    chg_d = chg_q | commit_new;
    if (clr_rd) begin
      chg_d = commit_new;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stable_q <= '0;
      chg_q    <= '0;
    end else begin
      stable_q <= stable_d;
      chg_q    <= chg_d;
    end
  end

  always_comb begin
    RD = ADDR_SEL ? 32'(chg_q) : 32'(stable_q);
  end

  assign IRQ = |chg_q;

endmodule

// File: tb/tb_sw_debounce_ctrl.sv
// Directed bench for sw_debounce_ctrl at N_SW=16, DEBOUNCE_CYCLES=4 (bypass scenario when SW_DEBOUNCE_BYPASS_EN is defined).
module tb_sw_debounce_ctrl;

  logic        CLK;
  logic        RST_N;
  logic [15:0] SW;
  logic        ADDR_SEL;
  logic        RD_EN;
  logic [31:0] RD;
  logic        IRQ;

  int total;
  int bad;

  sw_debounce_ctrl #(
    .N_SW(16),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .SW(SW),
    .ADDR_SEL(ADDR_SEL),
    .RD_EN(RD_EN),
    .RD(RD),
    .IRQ(IRQ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Leaves the bench 1 time unit after an edge with reset released; the next edge is edge 1
  task automatic do_reset(input logic [15:0] sw0);
    RST_N = 1'b0;
    SW = sw0;
    RD_EN = 1'b0;
    ADDR_SEL = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b1;
    SW = 16'h0000;
    RD_EN = 1'b0;
    ADDR_SEL = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    total++;
    if (RD !== 32'h0) begin bad++; $display("FAIL reset_rd_stable: got %h want %h", RD, 32'h0); end
    total++;
    if (IRQ !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", IRQ); end
    ADDR_SEL = 1'b1;
    #1;
    total++;
    if (RD !== 32'h0) begin bad++; $display("FAIL reset_rd_chg: got %h want %h", RD, 32'h0); end
    ADDR_SEL = 1'b0;
  endtask

  task automatic test_commit_latency();
    do_reset(16'h0000);
    SW = 16'h00A5;
    for (int e = 1; e <= 6; e++) begin
      tick();
      total++;
      if (RD !== 32'h0) begin bad++; $display("FAIL latency_early_edge%0d: got %h want %h", e, RD, 32'h0); end
    end
    tick();
    total++;
    if (RD !== 32'h000000A5) begin bad++; $display("FAIL latency_commit: got %h want %h", RD, 32'h000000A5); end
    total++;
    if (IRQ !== 1'b1) begin bad++; $display("FAIL latency_irq: got %b want 1", IRQ); end
    ADDR_SEL = 1'b1;
    #1;
    total++;
    if (RD !== 32'h000000A5) begin bad++; $display("FAIL latency_chg: got %h want %h", RD, 32'h000000A5); end
    RD_EN = 1'b1;
    tick();
    RD_EN = 1'b0;
    #1;
    total++;
    if (RD !== 32'h0) begin bad++; $display("FAIL clear_chg: got %h want %h", RD, 32'h0); end
    total++;
    if (IRQ !== 1'b0) begin bad++; $display("FAIL clear_irq: got %b want 0", IRQ); end
    ADDR_SEL = 1'b0;
  endtask

  task automatic test_glitch();
    do_reset(16'h0000);
    tick();
    tick();
    SW = 16'h0001;
    repeat (3) tick();
    SW = 16'h0000;
    for (int e = 0; e < 12; e++) begin
      tick();
      ADDR_SEL = 1'b0;
      #1;
      total++;
      if (RD !== 32'h0 || IRQ !== 1'b0) begin
        bad++;
        $display("FAIL glitch_stable_cyc%0d: got rd=%h irq=%b want rd=%h irq=0", e, RD, IRQ, 32'h0);
      end
      ADDR_SEL = 1'b1;
      #1;
      total++;
      if (RD !== 32'h0) begin bad++; $display("FAIL glitch_chg_cyc%0d: got %h want %h", e, RD, 32'h0); end
    end
    ADDR_SEL = 1'b0;
  endtask

  task automatic test_bounce();
    do_reset(16'h0000);
    SW = 16'h0001;
    tick();
    tick();
    SW = 16'h0000;
    tick();
    tick();
    SW = 16'h0001;
    for (int e = 5; e <= 10; e++) begin
      tick();
      total++;
      if (RD !== 32'h0) begin bad++; $display("FAIL bounce_early_edge%0d: got %h want %h", e, RD, 32'h0); end
    end
    tick();
    total++;
    if (RD !== 32'h00000001) begin bad++; $display("FAIL bounce_commit: got %h want %h", RD, 32'h00000001); end
    ADDR_SEL = 1'b1;
    #1;
    total++;
    if (RD !== 32'h00000001) begin bad++; $display("FAIL bounce_chg: got %h want %h", RD, 32'h00000001); end
    total++;
    if (IRQ !== 1'b1) begin bad++; $display("FAIL bounce_irq: got %b want 1", IRQ); end
    ADDR_SEL = 1'b0;
  endtask

  // Starts from stable=1, chg=1 left by test_bounce
  task automatic test_commit_and_clear();
    SW = 16'h0009;
    for (int e = 1; e <= 6; e++) begin
      tick();
      total++;
      if (RD !== 32'h00000001) begin bad++; $display("FAIL cc_hold_edge%0d: got %h want %h", e, RD, 32'h00000001); end
    end
    ADDR_SEL = 1'b1;
    RD_EN = 1'b1;
    #1;
    total++;
    if (RD !== 32'h00000001) begin bad++; $display("FAIL cc_preclear_rd: got %h want %h", RD, 32'h00000001); end
    tick();
    RD_EN = 1'b0;
    total++;
    if (RD !== 32'h00000008) begin bad++; $display("FAIL cc_chg_after: got %h want %h", RD, 32'h00000008); end
    total++;
    if (IRQ !== 1'b1) begin bad++; $display("FAIL cc_irq: got %b want 1", IRQ); end
    ADDR_SEL = 1'b0;
    #1;
    total++;
    if (RD !== 32'h00000009) begin bad++; $display("FAIL cc_stable: got %h want %h", RD, 32'h00000009); end
  endtask

  task automatic test_sel0_read_no_clear();
    ADDR_SEL = 1'b0;
    RD_EN = 1'b1;
    tick();
    RD_EN = 1'b0;
    ADDR_SEL = 1'b1;
    #1;
    total++;
    if (RD !== 32'h00000008) begin bad++; $display("FAIL sel0_read_chg: got %h want %h", RD, 32'h00000008); end
    total++;
    if (IRQ !== 1'b1) begin bad++; $display("FAIL sel0_read_irq: got %b want 1", IRQ); end
    ADDR_SEL = 1'b0;
  endtask

  // Starts from stable=9, chg=8
  task automatic test_reset_mid_settle();
    SW = 16'h0003;
    repeat (4) tick();
    #1;
    RST_N = 1'b0;
    #1;
    ADDR_SEL = 1'b1;
    #0.5;
    total++;
    if (RD !== 32'h0) begin bad++; $display("FAIL midreset_chg: got %h want %h", RD, 32'h0); end
    total++;
    if (IRQ !== 1'b0) begin bad++; $display("FAIL midreset_irq: got %b want 0", IRQ); end
    ADDR_SEL = 1'b0;
    #0.5;
    total++;
    if (RD !== 32'h0) begin bad++; $display("FAIL midreset_stable: got %h want %h", RD, 32'h0); end
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      total++;
      if (RD !== 32'h0) begin bad++; $display("FAIL midreset_early_edge%0d: got %h want %h", e, RD, 32'h0); end
    end
    tick();
    total++;
    if (RD !== 32'h00000003) begin bad++; $display("FAIL midreset_commit: got %h want %h", RD, 32'h00000003); end
  endtask

  task automatic test_bypass();
    do_reset(16'h0000);
    SW = 16'h8000;
    for (int e = 1; e <= 2; e++) begin
      tick();
      total++;
      if (RD !== 32'h0) begin bad++; $display("FAIL byp_early_edge%0d: got %h want %h", e, RD, 32'h0); end
    end
    tick();
    total++;
    if (RD !== 32'h00008000) begin bad++; $display("FAIL byp_commit: got %h want %h", RD, 32'h00008000); end
    ADDR_SEL = 1'b1;
    #1;
    total++;
    if (RD !== 32'h00008000) begin bad++; $display("FAIL byp_chg: got %h want %h", RD, 32'h00008000); end
    total++;
    if (IRQ !== 1'b1) begin bad++; $display("FAIL byp_irq: got %b want 1", IRQ); end
    RD_EN = 1'b1;
    tick();
    RD_EN = 1'b0;
    ADDR_SEL = 1'b0;
    SW = 16'h0000;
    tick();
    SW = 16'h8000;
    tick();
    total++;
    if (RD !== 32'h00008000) begin bad++; $display("FAIL byp_glitch_e2: got %h want %h", RD, 32'h00008000); end
    tick();
    total++;
    if (RD !== 32'h0) begin bad++; $display("FAIL byp_glitch_e3: got %h want %h", RD, 32'h0); end
    tick();
    total++;
    if (RD !== 32'h00008000) begin bad++; $display("FAIL byp_glitch_e4: got %h want %h", RD, 32'h00008000); end
    total++;
    if (IRQ !== 1'b1) begin bad++; $display("FAIL byp_glitch_irq: got %b want 1", IRQ); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
`ifdef SW_DEBOUNCE_BYPASS_EN
    test_bypass();
`else
    test_commit_latency();
    test_glitch();
    test_bounce();
    test_commit_and_clear();
    test_sel0_read_no_clear();
    test_reset_mid_settle();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
